// File: rtl/seq_playback_ctrl.sv
// Buffers 4-bit symbols and plays them onto a seven-segment decoder with on/gap timing.
// Optional end-of-sequence decimal point: define SEQ_PLAYBACK_DP_EN.
module seq_playback_ctrl #(
    parameter int DEPTH      = 16,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [3:0]                 wr_data,
    input  logic                       start,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       busy,
    output logic                       done,
    output logic [3:0]                 disp_val,
    output logic                       disp_blank,
    output logic                       disp_dp
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int IW   = $clog2(DEPTH);
    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int DW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      mem_q [DEPTH];
    logic            wr_fire;
    logic            full_w;
    logic            is_last;

    logic [3:0]      disp_val_q, disp_val_d;
    logic            disp_blank_q, disp_blank_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    assign full_w  = (count_q == CW'(DEPTH));
    assign is_last = (CW'(idx_q) == count_q - CW'(1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        count_d = count_q;
        wr_fire = 1'b0;
        if (clr) begin
            state_d = IDLE;
            idx_d   = '0;
            dwell_d = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (wr_en && !full_w) begin
                        wr_fire = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                    if (start) begin
                        if (count_q != '0) begin
                            state_d = SHOW;
                            idx_d   = '0;
                            dwell_d = DW'(ON_CYCLES - 1);
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                SHOW: begin
                    if (dwell_q == '0) begin
                        state_d = GAP;
                        dwell_d = DW'(OFF_CYCLES - 1);
                    end else begin
                        dwell_d = dwell_q - DW'(1);
                    end
                end
                GAP: begin
                    if (dwell_q == '0) begin
                        if (is_last) begin
                            state_d = DONE;
                        end else begin
                            state_d = SHOW;
                            idx_d   = idx_q + IW'(1);
                            dwell_d = DW'(ON_CYCLES - 1);
                        end
                    end else begin
                        dwell_d = dwell_q - DW'(1);
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered yet valid in the entry cycle.
    always_comb begin
        disp_val_d   = (state_d == SHOW) ? mem_q[idx_d] : 4'h0;
        disp_blank_d = (state_d != SHOW);
        busy_d       = (state_d == SHOW) || (state_d == GAP);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dwell_q      <= '0;
            count_q      <= '0;
            disp_val_q   <= '0;
            disp_blank_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dwell_q      <= dwell_d;
            count_q      <= count_d;
            disp_val_q   <= disp_val_d;
            disp_blank_q <= disp_blank_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Symbol storage is plain RAM: no reset, and clr only rewinds count.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[count_q[IW-1:0]] <= wr_data;
        end
    end

`ifdef SEQ_PLAYBACK_DP_EN
    logic dp_q, dp_d;

    always_comb begin
        dp_d = (state_d == SHOW) && (CW'(idx_d) == count_d - CW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_q <= 1'b0;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign disp_dp = dp_q;
`else
    assign disp_dp = 1'b0;
`endif

    assign count      = count_q;
    assign full       = full_w;
    assign busy       = busy_q;
    assign done       = done_q;
    assign disp_val   = disp_val_q;
    assign disp_blank = disp_blank_q;

endmodule

// File: doc/seq_playback_ctrl.md
# seq_playback_ctrl

Sequencing controller for the 4-bit seven-segment display decoder in the sequence memory game. It buffers a sequence of 4-bit symbols written by the game logic, then on command plays them onto the decoder one at a time. Each symbol is shown for a fixed on-time, followed by a blank gap. It owns the decoder's value and decimal-point inputs and provides a start/busy/done handshake to the game FSM.

## Interface
- `DEPTH`, 16: symbol buffer capacity; power of two, 2..64.
- `ON_CYCLES`, 25_000_000: clock cycles each symbol is displayed; must be ≥1.
- `OFF_CYCLES`, 12_500_000: blank clock cycles after each symbol; must be ≥1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clr`  in  1  empties the buffer and aborts any playback.
- `wr_en`  in  1  appends `wr_data` to the buffer.
- `wr_data`  in  4  symbol to append.
- `start`  in  1  begins playback of the buffered sequence.
- `count`  out  clog2(DEPTH+1)  number of symbols stored.
- `full`  out  1  high when `count == DEPTH`.
- `busy`  out  1  high while playback is in progress.
- `done`  out  1  one-cycle pulse when playback ends.
- `disp_val`  out  4  symbol to the decoder value input.
- `disp_blank`  out  1  high means the digit must be blanked by the display path.
- `disp_dp`  out  1  to the decoder decimal-point input.

## Operation
- **States:** IDLE, SHOW, GAP, DONE. Index register `idx` has width clog2(DEPTH); dwell counter has width clog2(max(ON_CYCLES,OFF_CYCLES)).
- **IDLE:**
  - `wr_en` with `!full` writes `buf[count]` and increments `count`.
  - `wr_en` with `full` is ignored.
  - `start` with `count > 0` sets `idx = 0`, loads the dwell counter, and enters SHOW.
  - `start` with `count == 0` enters DONE directly.
- **SHOW:**
  - `disp_val = buf[idx]`, `disp_blank = 0`.
  - After ON_CYCLES cycles in SHOW, enter GAP.
- **GAP:**
  - `disp_blank = 1`, `disp_val = 0`.
  - After OFF_CYCLES cycles, if `idx == count-1`, enter DONE; otherwise increment `idx` and enter SHOW.
- **DONE:** `done = 1` for exactly one cycle, then IDLE.
- **Buffer retention:** buffer contents and `count` are retained after playback, so `start` replays the same sequence.
- **`busy`:** high in SHOW and GAP; low in IDLE and DONE.
- **Ignored inputs:** `wr_en` and `start` are ignored outside IDLE.
- **`clr` handling:**
  - `clr` has priority over `wr_en` and `start` in the same cycle.
  - `clr` in any state sets `count = 0`, `idx = 0`, and goes to IDLE with no `done` pulse.
  - Buffer RAM contents need not be cleared.
- **Reset values:** all outputs 0, except `disp_blank = 1`. State is IDLE, `count = 0`, `idx = 0`.

## Timing
- `start` is sampled on edge T in IDLE. SHOW is entered at T+1, and `disp_val` is valid from T+1 (registered outputs).
- Symbol k is shown in cycles T+1+k·(ON+OFF) through T+k·(ON+OFF)+ON. Its blank gap follows for OFF cycles.
- `done` is high in cycle T+1+N·(ON+OFF), where N = `count`. `busy` is low in that cycle, and `start` is accepted again from the next cycle.
- Empty-buffer `start`: `done` is high at T+1, and `busy` never rises.
- `count` and `full` update the cycle after an accepted write.
- Asynchronous `reset` during SHOW or GAP immediately forces the reset values: blank display, no `done`.

## Configuration
- **`SEQ_PLAYBACK_DP_EN` defined:** `disp_dp = 1` during SHOW of the last symbol (`idx == count-1`) to mark end of sequence. It is 0 otherwise.
- **`SEQ_PLAYBACK_DP_EN` not defined:** `disp_dp` is tied to 0 and the comparison logic is not built.

## Test plan
All scenarios use DEPTH=4, ON_CYCLES=3, OFF_CYCLES=2.
- **Basic playback:** reset, write 5,A,3, then `start` at T.
  - `disp_val` = 5 at T+1..T+3, blank at T+4..T+5, A at T+6..T+8, 3 at T+11..T+13.
  - `done` pulses at T+16; `busy` is high at T+1..T+15.
- **Full buffer:** write 1,2,3,4,9. `count = 4`, `full = 1`, and a playback shows only 1,2,3,4 (9 dropped).
- **Empty start:** `start` with `count = 0` gives `done` at T+1, `busy` stays 0, and `disp_blank` stays 1.
- **Replay and ignored inputs:**
  - After a 2-symbol playback completes, a second `start` replays the identical sequence.
  - `wr_en`/`start` asserted during SHOW leave `count` and timing unchanged.
- **Abort:** `clr` at T+7 mid-playback gives IDLE, `count = 0`, `busy = 0`, and no `done` pulse ever. Asynchronous `reset` mid-GAP gives `disp_blank = 1` before the next edge.
- **Decimal point:** with `SEQ_PLAYBACK_DP_EN`, `disp_dp = 1` only while the last symbol is shown. Without it, `disp_dp` stays 0 throughout.
